// File: rtl/dmem_dump_ctrl_if.sv
// Debug dump stream between dmem_dump_ctrl (master) and a dump consumer (slave).
interface dmem_dump_ctrl_if #(
  parameter int N  = 64,
  parameter int AW = 6
);
  logic          dump_valid;
  logic          dump_ready;
  logic [N-1:0]  dump_data;
  logic [AW-1:0] dump_index;
  logic          dump_done;

  modport master (output dump_valid, dump_data, dump_index, dump_done, input dump_ready);
  modport slave  (input dump_valid, dump_data, dump_index, dump_done, output dump_ready);
endinterface

// File: rtl/dmem_dump_ctrl.sv
// LEGv8 data-memory arbiter: CPU passthrough, or a stalled walk streaming every word out.
// Optional: DMEM_DUMP_SKIP_ZERO_EN drops zero words from the stream.
module dmem_dump_ctrl #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  input  logic          cpu_we,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  input  logic [N-1:0]  mem_rdata,
  input  logic          dump,
  dmem_dump_ctrl_if.master dbg
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_dump_q;
  logic [N-1:0]  r_dump_data;
  logic [AW-1:0] r_dump_index;
  logic          w_capture;
  logic          w_last;
  logic          w_unused_addr;

  // Byte offset and high address bits are outside the memory's word range.
  assign w_unused_addr = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};
  assign w_last        = (r_ptr == {AW{1'b1}});

  assign cpu_rdata      = mem_rdata;
  assign dbg.dump_valid = (r_state == S_SEND);
  assign dbg.dump_done  = (r_state == S_DONE);
  assign dbg.dump_data  = r_dump_data;
  assign dbg.dump_index = r_dump_index;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_capture   = 1'b0;
    mem_addr    = cpu_addr[AW+2:3];
    mem_wdata   = cpu_wdata;
    mem_we      = cpu_we;
    cpu_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dump && !r_dump_q) begin
          w_ptr_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_addr  = r_ptr;
        mem_we    = 1'b0;
        cpu_stall = 1'b1;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        if (mem_rdata == '0) begin
          if (w_last) w_state_nxt = S_DONE;
          else        w_ptr_nxt   = r_ptr + 1'b1;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end
`else
        w_capture   = 1'b1;
        w_state_nxt = S_SEND;
`endif
      end
      S_SEND: begin
        mem_addr  = r_ptr;
        mem_we    = 1'b0;
        cpu_stall = 1'b1;
        if (dbg.dump_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE: begin
        // Held until the requester drops dump, so a still-high dump can't retrigger.
        if (!dump) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_dump_q     <= 1'b0;
      r_dump_data  <= '0;
      r_dump_index <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_dump_q <= dump;
      if (w_capture) begin
        r_dump_data  <= mem_rdata;
        r_dump_index <= r_ptr;
      end
    end
  end
endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed bench for dmem_dump_ctrl with a behavioural 64-word data memory.
module tb_dmem_dump_ctrl;
  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          gclk = 1'b0;
  logic          reset;
  logic [N-1:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_we, cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata, mem_rdata;
  logic          mem_we;
  logic          dump;
  logic [N-1:0]  mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  dmem_dump_ctrl_if #(.N(N), .AW(AW)) dbg_if ();

  dmem_dump_ctrl #(.N(N), .AW(AW)) dut (
    .CLOCK_50 (gclk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .dump     (dump),
    .dbg      (dbg_if)
  );

  always #5 gclk = ~gclk;

  assign mem_rdata = mem[mem_addr];
  always_ff @(posedge gclk) if (mem_we) mem[mem_addr] <= mem_wdata;

  function automatic logic [N-1:0] exp_word(input int i);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    return N'(3 * i + 1);
`else
    return N'(3 * i);
`endif
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic cpu_wr(input int w, input logic [N-1:0] d);
    cpu_addr  = N'(w) << 3;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  hit;
    reset = 1'b0; dump = 1'b1; cpu_we = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; dbg_if.dump_ready = 1'b0;

    // reset with dump and cpu_we asserted
    tick(); tick();
    chk("rst_valid", N'(dbg_if.dump_valid), 0);
    chk("rst_done",  N'(dbg_if.dump_done),  0);
    chk("rst_stall", N'(cpu_stall),         0);
    chk("rst_index", N'(dbg_if.dump_index), 0);
    reset = 1'b1; dump = 1'b0; cpu_we = 1'b0;
    tick(); tick();
    chk("post_rst_stall", N'(cpu_stall), 0);
    chk("post_rst_valid", N'(dbg_if.dump_valid), 0);

    // CPU passthrough
    cpu_addr = 64'h10; cpu_wdata = 64'hDEAD; cpu_we = 1'b1;
    #1;
    chk("pt_mem_addr", N'(mem_addr), 2);
    chk("pt_mem_we",   N'(mem_we),   1);
    chk("pt_wdata",    mem_wdata,    64'hDEAD);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("pt_rdata", cpu_rdata, 64'hDEAD);

    // full dump with ready tied high
    for (int i = 0; i < DEPTH; i++) cpu_wr(i, exp_word(i));
    dbg_if.dump_ready = 1'b1;
    dump = 1'b1;
    tick();
    for (int t = 0; t <= 2 * DEPTH; t++) begin
      if (t < 2 * DEPTH) begin
        chk("full_stall", N'(cpu_stall), 1);
        chk("full_done",  N'(dbg_if.dump_done), 0);
      end else begin
        chk("full_done_end",  N'(dbg_if.dump_done), 1);
        chk("full_stall_end", N'(cpu_stall), 0);
      end
      if (t % 2 == 1) begin
        chk("full_valid", N'(dbg_if.dump_valid), 1);
        chk("full_index", N'(dbg_if.dump_index), N'((t - 1) / 2));
        chk("full_data",  dbg_if.dump_data, exp_word((t - 1) / 2));
      end else begin
        chk("full_novalid", N'(dbg_if.dump_valid), 0);
      end
      tick();
    end
    chk("done_hold", N'(dbg_if.dump_done), 1);
    dump = 1'b0;
    tick();
    chk("done_clear", N'(dbg_if.dump_done), 0);

    // backpressure on beat 0
    dbg_if.dump_ready = 1'b0;
    dump = 1'b1;
    tick(); tick();
    dump = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", N'(dbg_if.dump_valid), 1);
      chk("bp_index", N'(dbg_if.dump_index), 0);
      chk("bp_data",  dbg_if.dump_data, exp_word(0));
      tick();
    end
    dbg_if.dump_ready = 1'b1;
    #1;
    chk("bp_still_valid", N'(dbg_if.dump_valid), 1);
    tick();
    chk("bp_load", N'(dbg_if.dump_valid), 0);
    tick();
    chk("bp_b1_index", N'(dbg_if.dump_index), 1);
    chk("bp_b1_data",  dbg_if.dump_data, exp_word(1));

    // write isolation, then reset at beat 10
    cpu_addr = 64'h18; cpu_wdata = 64'hBAD; cpu_we = 1'b1;
    #1;
    chk("iso_mem_we", N'(mem_we), 0);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (dbg_if.dump_valid && dbg_if.dump_index == AW'(10)) hit = 1'b1;
      else tick();
    end
    chk("reach_beat10", N'(hit), 1);
    chk("iso_mem_we_b10", N'(mem_we), 0);
    reset = 1'b0; cpu_we = 1'b0;
    tick();
    chk("mid_rst_valid", N'(dbg_if.dump_valid), 0);
    chk("mid_rst_stall", N'(cpu_stall), 0);
    chk("mid_rst_done",  N'(dbg_if.dump_done), 0);
    reset = 1'b1;
    #1;
    chk("iso_mem_kept", cpu_rdata, exp_word(3));
    dump = 1'b1;
    tick(); tick();
    chk("restart_valid", N'(dbg_if.dump_valid), 1);
    chk("restart_index", N'(dbg_if.dump_index), 0);
    chk("restart_data",  dbg_if.dump_data, exp_word(0));
    reset = 1'b0; dump = 1'b0;
    tick();
    reset = 1'b1;

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    for (int i = 0; i < DEPTH; i++) cpu_wr(i, '0);
    cpu_wr(5, 64'd7);
    cpu_wr(63, 64'd1);
    dump = 1'b1;
    tick();
    cnt = 0; hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (dbg_if.dump_valid) begin
        if (cnt == 0) begin
          chk("skip_b0_index", N'(dbg_if.dump_index), 5);
          chk("skip_b0_data",  dbg_if.dump_data, 7);
        end else if (cnt == 1) begin
          chk("skip_b1_index", N'(dbg_if.dump_index), 63);
          chk("skip_b1_data",  dbg_if.dump_data, 1);
        end
        cnt++;
      end
      if (dbg_if.dump_done) hit = 1'b1;
      else tick();
    end
    chk("skip_done", N'(hit), 1);
    chk("skip_beats", N'(cnt), 2);
    dump = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
